// File: rtl/clock_divider_prog.sv
// rtl/clock_divider_prog.sv - runtime-programmable clock divider with tick strobe
//
// Divides clk by a divisor D that can be reloaded at runtime. A new divisor
// is held as pending and only takes effect at a period boundary (or
// immediately while stopped or restarting), so periods are never truncated.
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   en          count enable; when low, counter and clk_out hold
//   restart     synchronous phase restart (counter and clk_out to 0)
//   div_load    one-cycle request to load div_value
//   div_value   requested divisor (input cycles per output period)
//   clk_out     divided clock: low floor(D/2) cycles, high ceil(D/2) cycles
//   tick        one-cycle pulse on the last cycle of each period
//   load_err    one-cycle pulse when a divisor below 2 is rejected
//   pending     a loaded divisor is waiting to be applied
//   div_active  divisor currently in effect
module clock_divider_prog #(
  parameter int unsigned      WIDTH       = 32,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(100_000_000)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic             div_load,
  input  logic [WIDTH-1:0] div_value,
  output logic             clk_out,
  output logic             tick,
  output logic             load_err,
  output logic             pending,
  output logic [WIDTH-1:0] div_active
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] pend;

  logic             at_end;
  logic             boundary;
  logic             load_ok;
  logic             load_bad;
  logic [WIDTH-1:0] d_eff;
  logic [WIDTH-1:0] cnt_inc;

  always_comb begin
    at_end   = (cnt == div_active - ONE);
    boundary = at_end && pending;
    load_ok  = div_load && (div_value >= TWO);
    load_bad = div_load && (div_value < TWO);
    // At a boundary with a pending divisor, the next period (starting at
    // cnt=0) already runs with the new value, so outputs use it too.
    d_eff    = boundary ? pend : div_active;
    // cnt never exceeds D-1, so cnt+1 cannot wrap even for D = 2^WIDTH-1.
    cnt_inc  = at_end ? '0 : cnt + ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      clk_out    <= 1'b0;
      tick       <= 1'b0;
      load_err   <= 1'b0;
      pending    <= 1'b0;
      pend       <= '0;
      div_active <= DEFAULT_DIV;
    end else begin
      tick     <= 1'b0;
      load_err <= load_bad;

      if (restart || !en) begin
        // Stopped or restarting: a waiting divisor is applied right away
        // and the phase restarts from zero.
        if (pending) begin
          div_active <= pend;
          pending    <= 1'b0;
          cnt        <= '0;
          clk_out    <= 1'b0;
        end else if (restart) begin
          cnt     <= '0;
          clk_out <= 1'b0;
        end
      end else begin
        cnt     <= cnt_inc;
        clk_out <= (cnt_inc >= (d_eff >> 1));
        tick    <= (cnt_inc == d_eff - ONE);
        if (boundary) begin
          div_active <= pend;
          pending    <= 1'b0;
        end
      end

      // Capture after the apply logic so a load coinciding with an apply
      // becomes the next pending value rather than being lost.
      if (load_ok) begin
        pend    <= div_value;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_clock_divider_prog.sv
// tb/tb_clock_divider_prog.sv - directed self-checking bench for clock_divider_prog
module tb_clock_divider_prog;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             en;
  logic             restart;
  logic             div_load;
  logic [WIDTH-1:0] div_value;
  logic             clk_out;
  logic             tick;
  logic             load_err;
  logic             pending;
  logic [WIDTH-1:0] div_active;

  int n_vec;
  int n_err;

  clock_divider_prog #(
    .WIDTH      (WIDTH),
    .DEFAULT_DIV(8'd10)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .restart   (restart),
    .div_load  (div_load),
    .div_value (div_value),
    .clk_out   (clk_out),
    .tick      (tick),
    .load_err  (load_err),
    .pending   (pending),
    .div_active(div_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    div_load  = 1'b1;
    div_value = v;
    step();
    div_load  = 1'b0;
  endtask

  // Expect `low` low cycles then `high` high cycles; tick only on the final
  // high cycle when last_is_tick is set.
  task automatic expect_wave(input string tag, input int low, input int high, input bit last_is_tick);
    for (int i = 0; i < low; i++) begin
      check({tag, "_lo_clk"}, 32'(clk_out), 32'd0);
      check({tag, "_lo_tick"}, 32'(tick), 32'd0);
      step();
    end
    for (int i = 0; i < high; i++) begin
      check({tag, "_hi_clk"}, 32'(clk_out), 32'd1);
      check({tag, "_hi_tick"}, 32'(tick), 32'(last_is_tick && (i == high - 1)));
      step();
    end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    en        = 1'b0;
    restart   = 1'b0;
    div_load  = 1'b0;
    div_value = '0;
    #1;
    step();
    step();

    // Reset state
    check("rst_clk", 32'(clk_out), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    check("rst_err", 32'(load_err), 32'd0);
    check("rst_pend", 32'(pending), 32'd0);
    check("rst_div", 32'(div_active), 32'd10);

    // Default divisor 10: low 5 / high 5
    rst = 1'b0;
    en  = 1'b1;
    expect_wave("d10a", 5, 5, 1);
    expect_wave("d10b", 5, 5, 1);

    // Odd divisor 3 loaded at cnt=0, applied at the boundary
    load(8'd3);
    check("odd_pend", 32'(pending), 32'd1);
    check("odd_div_old", 32'(div_active), 32'd10);
    expect_wave("odd_rest", 4, 5, 1);
    check("odd_div", 32'(div_active), 32'd3);
    check("odd_pend_clr", 32'(pending), 32'd0);
    for (int r = 0; r < 3; r++) expect_wave("d3", 1, 2, 1);

    // Back to 10, then load 4 at cnt=4
    load(8'd10);
    expect_wave("to10", 0, 2, 1);
    expect_wave("mid_pre", 4, 0, 0);
    load(8'd4);
    check("mid_pend", 32'(pending), 32'd1);
    check("mid_div_old", 32'(div_active), 32'd10);
    expect_wave("mid_rest", 0, 5, 1);
    check("mid_div", 32'(div_active), 32'd4);
    for (int r = 0; r < 2; r++) expect_wave("d4", 2, 2, 1);

    // Rejected loads and overwrite
    load(8'd1);
    check("rej1_err", 32'(load_err), 32'd1);
    check("rej1_pend", 32'(pending), 32'd0);
    check("rej1_div", 32'(div_active), 32'd4);
    step();
    check("rej1_err_clr", 32'(load_err), 32'd0);
    load(8'd0);
    check("rej0_err", 32'(load_err), 32'd1);
    check("rej0_pend", 32'(pending), 32'd0);
    step();
    check("rej0_err_clr", 32'(load_err), 32'd0);
    check("rej0_div", 32'(div_active), 32'd4);
    load(8'd6);
    load(8'd8);
    check("ow_pend", 32'(pending), 32'd1);
    check("ow_div_old", 32'(div_active), 32'd4);
    expect_wave("ow_rest", 0, 2, 1);
    check("ow_div", 32'(div_active), 32'd8);
    check("ow_pend_clr", 32'(pending), 32'd0);
    expect_wave("d8", 4, 4, 1);

    // en low for 7 cycles at cnt=5 holds the phase
    expect_wave("hold_pre", 4, 1, 0);
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      check("hold_clk", 32'(clk_out), 32'd1);
      check("hold_tick", 32'(tick), 32'd0);
    end
    en = 1'b1;
    expect_wave("hold_rest", 0, 3, 1);

    // restart at cnt=6
    expect_wave("rs_pre", 4, 2, 0);
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("rs_clk", 32'(clk_out), 32'd0);
    check("rs_tick", 32'(tick), 32'd0);
    expect_wave("rs_post", 4, 4, 1);

    // Reset mid-period with a pending load
    expect_wave("mr_pre", 3, 0, 0);
    load(8'd5);
    check("mr_pend_set", 32'(pending), 32'd1);
    expect_wave("mr_mid", 0, 3, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mr_div", 32'(div_active), 32'd10);
    check("mr_pend", 32'(pending), 32'd0);
    check("mr_clk", 32'(clk_out), 32'd0);
    check("mr_tick", 32'(tick), 32'd0);

    // Load on the exact boundary cycle takes effect one period later
    expect_wave("bl_pre", 5, 4, 0);
    load(8'd6);
    check("bl_div_old", 32'(div_active), 32'd10);
    check("bl_pend", 32'(pending), 32'd1);
    expect_wave("bl_d10", 5, 5, 1);
    check("bl_div", 32'(div_active), 32'd6);
    check("bl_pend_clr", 32'(pending), 32'd0);
    expect_wave("bl_d6", 3, 3, 1);

    // Pending value applied at a boundary while a new load arrives
    load(8'd2);
    expect_wave("sim_pre", 2, 2, 0);
    load(8'd3);
    check("sim_div", 32'(div_active), 32'd2);
    check("sim_pend", 32'(pending), 32'd1);
    expect_wave("sim_d2", 1, 1, 1);
    check("sim_div2", 32'(div_active), 32'd3);
    check("sim_pend_clr", 32'(pending), 32'd0);
    expect_wave("sim_d3", 1, 2, 1);

    // Largest divisor at this width
    load(8'd255);
    expect_wave("max_pre", 0, 2, 1);
    check("max_div", 32'(div_active), 32'd255);
    expect_wave("d255", 127, 128, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
